// File: rtl/candidate_buffer.sv
// Slot buffer of (data, key) entries with lowest-free allocation, indexed release and a
// registered candidate mask marking valid slots whose key meets the current threshold.
module candidate_buffer #(
    parameter  int BS  = 16,
    parameter  int DW  = 32,
    parameter  int KW  = 8,
    localparam int BSB = $clog2(BS),
    localparam int CW  = $clog2(BS + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_data,
    input  logic [KW-1:0]  in_key,
    input  logic [KW-1:0]  threshold,
    output logic [BS-1:0]  cand_list,
    input  logic           rel_valid,
    input  logic [BSB-1:0] rel_index,
    output logic           out_valid,
    output logic [DW-1:0]  out_data,
    output logic           rel_err,
    output logic [CW-1:0]  count,
    output logic           full,
    output logic           empty
);

    logic [BS-1:0]  vld_q, vld_d;
    logic [BS-1:0]  cand_q, cand_d;
    logic [CW-1:0]  count_q, count_d;
    logic           out_valid_q;
    logic [DW-1:0]  out_data_q;
    logic           rel_err_q;

    logic [DW-1:0]  data_q [BS];
    logic [KW-1:0]  key_q  [BS];
    logic [KW-1:0]  key_next [BS];

    logic [BSB-1:0] alloc_idx;
    logic           alloc_found;
    logic           wr_acc;
    logic           rel_in_range;
    logic           rel_ok;

    assign full     = (count_q == CW'(BS));
    assign empty    = (count_q == '0);
    assign in_ready = ~full;
    assign wr_acc   = in_valid & in_ready;

    // Lowest free slot; scanning downward lets the last hit (lowest index) win.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = BS - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                alloc_idx   = BSB'(i);
                alloc_found = 1'b1;
            end
        end
    end

    always_comb begin
        rel_in_range = (int'(rel_index) < BS);
        rel_ok       = 1'b0;
        if (rel_valid && rel_in_range) begin
            rel_ok = vld_q[rel_index];
        end
    end

    // Allocation draws from the pre-edge free set, so it never collides with the released slot.
    always_comb begin
        vld_d = vld_q;
        if (rel_ok) begin
            vld_d[rel_index] = 1'b0;
        end
        if (wr_acc) begin
            vld_d[alloc_idx] = 1'b1;
        end
    end

    always_comb begin
        cand_d = '0;
        for (int i = 0; i < BS; i++) begin
            key_next[i] = (wr_acc && alloc_idx == BSB'(i)) ? in_key : key_q[i];
            cand_d[i]   = vld_d[i] && (key_next[i] >= threshold);
        end
    end

    assign count_d = count_q + CW'(wr_acc) - CW'(rel_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            vld_q       <= '0;
            cand_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rel_err_q   <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            cand_q      <= cand_d;
            count_q     <= count_d;
            out_valid_q <= rel_ok;
            rel_err_q   <= rel_valid & ~rel_ok;
            if (rel_ok) begin
                out_data_q <= data_q[rel_index];
            end
        end
    end

    // NOTE: payload/key storage is deliberately not reset; a slot is only read while its vld bit is set.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            data_q[alloc_idx] <= in_data;
            key_q[alloc_idx]  <= in_key;
        end
    end

    assign cand_list = cand_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign rel_err   = rel_err_q;
    assign count     = count_q;

    a_count_matches_vld: assert property (@(posedge clk) disable iff (rst)
        count_q == CW'($countones(vld_q)));

    a_ready_has_free_slot: assert property (@(posedge clk) disable iff (rst)
        in_ready |-> alloc_found);

endmodule

// File: tb/tb_candidate_buffer.sv
// Directed self-checking bench for candidate_buffer: fill, threshold, release,
// simultaneous write/release, bad release and mid-operation reset.
module tb_candidate_buffer;

    localparam int BS  = 16;
    localparam int DW  = 32;
    localparam int KW  = 8;
    localparam int BSB = 4;
    localparam int CW  = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [KW-1:0]  in_key;
    logic [KW-1:0]  threshold;
    logic [BS-1:0]  cand_list;
    logic           rel_valid;
    logic [BSB-1:0] rel_index;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic           rel_err;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;

    int tests = 0;
    int fails = 0;

    candidate_buffer #(.BS(BS), .DW(DW), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .threshold (threshold),
        .cand_list (cand_list),
        .rel_valid (rel_valid),
        .rel_index (rel_index),
        .out_valid (out_valid),
        .out_data  (out_data),
        .rel_err   (rel_err),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dval(input int i);
        return 32'hD000_0000 | DW'(i);
    endfunction

    // One rising edge, then settle 1ns so outputs reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0; rel_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_entry(input logic [KW-1:0] k, input logic [DW-1:0] d);
        in_valid = 1'b1; in_key = k; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_slot(input int idx);
        rel_valid = 1'b1; rel_index = BSB'(idx);
        tick();
        rel_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (count !== 5'd0)     begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
        tests++; if (cand_list !== 16'h0) begin fails++; $display("FAIL reset_cand got=%h exp=0000", cand_list); end
        tests++; if ({empty, full, in_ready} !== 3'b101) begin fails++; $display("FAIL reset_flags got=%b exp=101", {empty, full, in_ready}); end
        tests++; if ({out_valid, rel_err} !== 2'b00) begin fails++; $display("FAIL reset_pulses got=%b exp=00", {out_valid, rel_err}); end
        tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    endtask

    task automatic test_fill();
        threshold = 8'd0;
        for (int i = 0; i < BS; i++) begin
            if (i == BS - 1) begin
                tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fill_ready_at15 got=%b exp=1", in_ready); end
            end
            write_entry(KW'(i), dval(i));
            if (i == 0) begin
                tests++; if (cand_list !== 16'h0001) begin fails++; $display("FAIL fill_first_cand got=%h exp=0001", cand_list); end
                tests++; if (count !== 5'd1) begin fails++; $display("FAIL fill_first_count got=%0d exp=1", count); end
            end
        end
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL fill_count got=%0d exp=16", count); end
        tests++; if ({full, empty, in_ready} !== 3'b100) begin fails++; $display("FAIL fill_flags got=%b exp=100", {full, empty, in_ready}); end
        tests++; if (cand_list !== 16'hFFFF) begin fails++; $display("FAIL fill_cand got=%h exp=FFFF", cand_list); end
    endtask

    task automatic test_threshold();
        threshold = 8'd8;
        tick();
        tests++; if (cand_list !== 16'hFF00) begin fails++; $display("FAIL thr8_cand got=%h exp=FF00", cand_list); end
        threshold = 8'd15;
        tick();
        tests++; if (cand_list !== 16'h8000) begin fails++; $display("FAIL thr15_cand got=%h exp=8000", cand_list); end
        threshold = 8'd16;
        tick();
        tests++; if (cand_list !== 16'h0000) begin fails++; $display("FAIL thr16_cand got=%h exp=0000", cand_list); end
        threshold = 8'd0;
        tick();
        tests++; if (cand_list !== 16'hFFFF) begin fails++; $display("FAIL thr0_cand got=%h exp=FFFF", cand_list); end
    endtask

    task automatic test_release();
        release_slot(3);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rel3_out_valid got=%b exp=1", out_valid); end
        tests++; if (out_data !== dval(3)) begin fails++; $display("FAIL rel3_out_data got=%h exp=%h", out_data, dval(3)); end
        tests++; if (cand_list !== 16'hFFF7) begin fails++; $display("FAIL rel3_cand got=%h exp=FFF7", cand_list); end
        tests++; if (count !== 5'd15) begin fails++; $display("FAIL rel3_count got=%0d exp=15", count); end
        tick();
        tests++; if ({out_valid, out_data} !== {1'b0, dval(3)}) begin fails++; $display("FAIL rel3_hold got=%b/%h exp=0/%h", out_valid, out_data, dval(3)); end
        write_entry(8'd20, 32'hCAFE_0003);
        tests++; if (cand_list !== 16'hFFFF) begin fails++; $display("FAIL refill_cand got=%h exp=FFFF", cand_list); end
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL refill_count got=%0d exp=16", count); end
        // Full: release plus offered write in one cycle; the write must not happen.
        in_valid = 1'b1; in_key = 8'd1; in_data = 32'hBAD0_BAD0;
        rel_valid = 1'b1; rel_index = 4'd5;
        tick();
        in_valid = 1'b0; rel_valid = 1'b0;
        tests++; if (count !== 5'd15) begin fails++; $display("FAIL full_relwr_count got=%0d exp=15", count); end
        tests++; if (cand_list !== 16'hFFDF) begin fails++; $display("FAIL full_relwr_cand got=%h exp=FFDF", cand_list); end
        tests++; if (out_data !== dval(5)) begin fails++; $display("FAIL full_relwr_data got=%h exp=%h", out_data, dval(5)); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_relwr_ready got=%b exp=1", in_ready); end
        release_slot(3);
        tests++; if (out_data !== 32'hCAFE_0003) begin fails++; $display("FAIL slot3_reuse got=%h exp=CAFE0003", out_data); end
        tests++; if (cand_list !== 16'hFFD7) begin fails++; $display("FAIL slot3_reuse_cand got=%h exp=FFD7", cand_list); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        threshold = 8'd0;
        for (int i = 0; i < 5; i++) write_entry(KW'(i + 1), dval(i));
        tests++; if (count !== 5'd5) begin fails++; $display("FAIL b2b_pre_count got=%0d exp=5", count); end
        in_valid = 1'b1; in_key = 8'd7; in_data = 32'h1234_5678;
        rel_valid = 1'b1; rel_index = 4'd2;
        tick();
        in_valid = 1'b0; rel_valid = 1'b0;
        tests++; if (cand_list !== 16'h003B) begin fails++; $display("FAIL b2b_cand got=%h exp=003B", cand_list); end
        tests++; if (count !== 5'd5) begin fails++; $display("FAIL b2b_count got=%0d exp=5", count); end
        tests++; if ({out_valid, out_data} !== {1'b1, dval(2)}) begin fails++; $display("FAIL b2b_out got=%b/%h exp=1/%h", out_valid, out_data, dval(2)); end
        release_slot(5);
        tests++; if ({out_valid, out_data} !== {1'b1, 32'h1234_5678}) begin fails++; $display("FAIL b2b_slot5 got=%b/%h exp=1/12345678", out_valid, out_data); end
    endtask

    task automatic test_rel_err();
        // Slots 0,1,3,4 valid here.
        release_slot(9);
        tests++; if ({rel_err, out_valid} !== 2'b10) begin fails++; $display("FAIL err_pulse got=%b exp=10", {rel_err, out_valid}); end
        tests++; if (count !== 5'd4) begin fails++; $display("FAIL err_count got=%0d exp=4", count); end
        tests++; if (cand_list !== 16'h001B) begin fails++; $display("FAIL err_cand got=%h exp=001B", cand_list); end
        tests++; if (out_data !== 32'h1234_5678) begin fails++; $display("FAIL err_out_data got=%h exp=12345678", out_data); end
        tick();
        tests++; if (rel_err !== 1'b0) begin fails++; $display("FAIL err_one_cycle got=%b exp=0", rel_err); end
        release_slot(2);
        tests++; if ({rel_err, count} !== {1'b1, 5'd4}) begin fails++; $display("FAIL err_freed_slot got=%b/%0d exp=1/4", rel_err, count); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        threshold = 8'd0;
        for (int i = 0; i < 7; i++) write_entry(KW'(i), dval(i));
        tests++; if (count !== 5'd7) begin fails++; $display("FAIL mrst_pre_count got=%0d exp=7", count); end
        in_valid = 1'b1; in_key = 8'd9; in_data = 32'hEEEE_EEEE;
        rel_valid = 1'b1; rel_index = 4'd0;
        #2 rst = 1'b1;
        #1;
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL mrst_async_count got=%0d exp=0", count); end
        tests++; if ({cand_list, empty} !== {16'h0, 1'b1}) begin fails++; $display("FAIL mrst_async_state got=%h/%b exp=0000/1", cand_list, empty); end
        tick();
        rst = 1'b0; in_valid = 1'b0; rel_valid = 1'b0;
        tests++; if ({count, out_valid, rel_err} !== {5'd0, 2'b00}) begin fails++; $display("FAIL mrst_hold got=%0d/%b/%b exp=0/0/0", count, out_valid, rel_err); end
        write_entry(8'd3, 32'h5A5A_0000);
        tests++; if (cand_list !== 16'h0001) begin fails++; $display("FAIL mrst_first_cand got=%h exp=0001", cand_list); end
        release_slot(0);
        tests++; if ({out_valid, out_data} !== {1'b1, 32'h5A5A_0000}) begin fails++; $display("FAIL mrst_slot0 got=%b/%h exp=1/5A5A0000", out_valid, out_data); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0;
        threshold = '0; rel_valid = 1'b0; rel_index = '0;
        repeat (2) tick();
        test_reset();
        test_fill();
        test_threshold();
        test_release();
        test_back_to_back();
        test_rel_err();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
